// File: rtl/dll_tx_arbiter.sv
// rtl/dll_tx_arbiter.sv - PIPE TX arbiter: fixed-priority/WRR packet merge with DLLP starvation bound
`timescale 1ns/1ps

module dll_tx_arbiter #(
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_SRC      = 3,
  parameter int WEIGHT_WIDTH = 4,
  parameter int STARVE_LG2   = 8
) (
  input  logic                            sclk,
  input  logic                            srst,
  input  logic                            mode_i,
  input  logic [NUM_SRC*WEIGHT_WIDTH-1:0] weight_i,
  input  logic [STARVE_LG2-1:0]           starve_limit_i,
  input  logic                            link_up_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]              src_last_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  output logic [NUM_SRC-1:0]              grant_o,
  output logic [DATA_WIDTH-1:0]           pipe_txdata_o,
  output logic                            pipe_txvalid_o,
  input  logic                            pipe_txready_i,
  output logic                            starve_event_o
);

  localparam int IW = $clog2(NUM_SRC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q [NUM_SRC];
  logic [WEIGHT_WIDTH-1:0] credit_d [NUM_SRC];
  logic [STARVE_LG2-1:0]   starve_cnt_q;
  logic [DATA_WIDTH-1:0]   txdata_q;
  logic                    txvalid_q;

  logic                    slot_free;
  logic [NUM_SRC-1:0]      elig;
  logic                    starve_hit;
  logic                    fp_found, rr_found;
  int                      rr_idx;
  logic [IW-1:0]           rr_cand;
  logic [IW-1:0]           fp_win, rr_win, win;
  logic [WEIGHT_WIDTH-1:0] win_weight_raw, win_weight, win_credit;
  logic [NUM_SRC-1:0]      ready_c, grant_c;
  logic                    event_c;
  logic [IW-1:0]           sel;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   sel_data;

  // The output register can take a beat when empty or draining this cycle.
  assign slot_free = ~txvalid_q | pipe_txready_i;
  // TLP and replay sources stay masked until the link reaches DL_Active.
  assign elig = link_up_i ? src_valid_i : {{(NUM_SRC-1){1'b0}}, src_valid_i[0]};
  // DLLP source has waited long enough; it wins the next IDLE arbitration.
  assign starve_hit = (starve_limit_i != '0) && (starve_cnt_q >= starve_limit_i) && src_valid_i[0];

  // Candidate winners: lowest eligible index, and first eligible at or after ptr.
  always_comb begin
    fp_win   = '0;
    rr_win   = ptr_q;
    fp_found = 1'b0;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!fp_found && elig[i]) begin
        fp_win   = IW'(i);
        fp_found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
      rr_cand = IW'(rr_idx);
      if (!rr_found && elig[rr_cand]) begin
        rr_win   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  assign win            = starve_hit ? '0 : (mode_i ? rr_win : fp_win);
  assign win_weight_raw = weight_i[win*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign win_weight     = (win_weight_raw == '0) ? WEIGHT_WIDTH'(1) : win_weight_raw;
  // A source entering its turn away from ptr starts with a full credit load.
  assign win_credit     = (win != ptr_q) ? win_weight : credit_q[win];

  // Packet-ownership FSM, ready/grant generation and WRR pointer/credit update.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    ready_c  = '0;
    grant_c  = '0;
    event_c  = 1'b0;
    sel      = owner_q;
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free && (|elig)) begin
          sel          = win;
          ready_c[win] = 1'b1;
          grant_c[win] = 1'b1;
          event_c      = starve_hit;
          xfer         = 1'b1;
          if (!src_last_i[win]) begin
            state_d = BURST;
            owner_d = win;
          end
          if (mode_i && !starve_hit) begin
            if (win_credit > WEIGHT_WIDTH'(1)) begin
              credit_d[win] = win_credit - 1'b1;
              ptr_d         = win;
            end else begin
              credit_d[win] = win_weight;
              ptr_d         = (win == LAST_IDX) ? '0 : win + 1'b1;
            end
          end
        end
      end
      BURST: begin
        grant_c[owner_q] = 1'b1;
        ready_c[owner_q] = slot_free;
        xfer             = slot_free & src_valid_i[owner_q];
        if (xfer && src_last_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_data = src_data_i[sel*DATA_WIDTH +: DATA_WIDTH];

  // State, owner and WRR bookkeeping registers.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) credit_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // Single PIPE output stage: load on transfer, clear when drained with nothing new.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      txdata_q  <= '0;
      txvalid_q <= 1'b0;
    end else if (xfer) begin
      txdata_q  <= sel_data;
      txvalid_q <= 1'b1;
    end else if (pipe_txready_i) begin
      txvalid_q <= 1'b0;
    end
  end

  // Saturating wait counter for the DLLP source; cleared whenever it owns the path.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      starve_cnt_q <= '0;
    end else if (grant_c[0]) begin
      starve_cnt_q <= '0;
    end else if (src_valid_i[0] && (starve_cnt_q != '1)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Nothing is offered to sources or PIPE while reset is held.
  assign src_ready_o    = srst ? '0 : ready_c;
  assign grant_o        = srst ? '0 : grant_c;
  assign starve_event_o = ~srst & event_c;
  assign pipe_txdata_o  = txdata_q;
  assign pipe_txvalid_o = txvalid_q;

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// tb/tb_dll_tx_arbiter.sv - self-checking bench for dll_tx_arbiter
`timescale 1ns/1ps

module tb_dll_tx_arbiter;

  localparam int DW = 32;
  localparam int NS = 3;
  localparam int WW = 4;
  localparam int SL = 8;

  logic              sclk = 1'b0;
  logic              srst;
  logic              mode;
  logic [NS*WW-1:0]  weight;
  logic [SL-1:0]     starve_limit;
  logic              link_up;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_last;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     grant;
  logic [DW-1:0]     pipe_txdata;
  logic              pipe_txvalid;
  logic              pipe_txready;
  logic              starve_event;

  always #5 sclk = ~sclk;

  dll_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .WEIGHT_WIDTH(WW), .STARVE_LG2(SL)) dut (
    .sclk(sclk), .srst(srst), .mode_i(mode), .weight_i(weight), .starve_limit_i(starve_limit),
    .link_up_i(link_up), .src_valid_i(src_valid), .src_data_i(src_data), .src_last_i(src_last),
    .src_ready_o(src_ready), .grant_o(grant), .pipe_txdata_o(pipe_txdata),
    .pipe_txvalid_o(pipe_txvalid), .pipe_txready_i(pipe_txready), .starve_event_o(starve_event)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int            m_burst, m_owner, m_ptr, m_cnt, m_pv;
  logic [DW-1:0] m_pd;
  int            m_credit [NS];
  logic [NS-1:0] e_ready, e_grant;
  logic          e_event;
  int            e_acc;

  // random source state
  int            s_left [NS];
  logic [DW-1:0] s_data [NS];

  // directed tables
  int            wrr_exp [13] = '{0, 1, 2, 0, 1, 1, 1, 2, 0, 1, 1, 1, 2};
  int            stv_exp [12] = '{0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  logic [NS-1:0] bp_v    [10] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000, 3'b000};
  int            bp_beat [10] = '{0, 1, 2, 2, 2, 2, 3, 3, 3, 3};
  logic          bp_txr  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [NS-1:0] bp_rdy  [10] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
  logic [NS-1:0] bp_gnt  [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
  logic          bp_pv   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] bp_pd   [10] = '{32'h0, 32'hB000_0000, 32'hB000_0001, 32'hB000_0001, 32'hB000_0001,
                                  32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hA000_0000, 32'h0};

  function automatic bit eligible(int i);
    return src_valid[i] && (link_up || i == 0);
  endfunction

  function automatic int eff_weight(int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_burst = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_pv = 0; m_pd = '0;
    for (int i = 0; i < NS; i++) begin
      m_credit[i] = 0;
      s_left[i]   = 0;
      s_data[i]   = '0;
    end
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic model_eval();
    bit slot_free;
    int w;
    slot_free = (m_pv == 0) || pipe_txready;
    e_ready = '0; e_grant = '0; e_event = 1'b0; e_acc = -1; w = -1;
    if (m_burst != 0) begin
      e_grant[m_owner] = 1'b1;
      if (slot_free) begin
        e_ready[m_owner] = 1'b1;
        if (src_valid[m_owner]) e_acc = m_owner;
      end
    end else if (slot_free) begin
      if (starve_limit != 0 && m_cnt >= int'(starve_limit) && src_valid[0]) begin
        w = 0;
        e_event = 1'b1;
      end else if (!mode) begin
        for (int i = NS - 1; i >= 0; i--) if (eligible(i)) w = i;
      end else begin
        for (int k = NS - 1; k >= 0; k--) if (eligible((m_ptr + k) % NS)) w = (m_ptr + k) % NS;
      end
      if (w >= 0) begin
        e_grant[w] = 1'b1;
        e_ready[w] = 1'b1;
        e_acc = w;
      end
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_commit();
    int cr;
    if (m_burst == 0 && e_acc >= 0) begin
      if (mode && !e_event) begin
        cr = (e_acc != m_ptr) ? eff_weight(e_acc) : m_credit[e_acc];
        if (cr > 1) begin
          m_credit[e_acc] = cr - 1;
          m_ptr = e_acc;
        end else begin
          m_credit[e_acc] = eff_weight(e_acc);
          m_ptr = (e_acc + 1) % NS;
        end
      end
      if (!src_last[e_acc]) begin
        m_burst = 1;
        m_owner = e_acc;
      end
    end else if (m_burst != 0 && e_acc >= 0 && src_last[e_acc]) begin
      m_burst = 0;
    end
    if (e_grant[0]) m_cnt = 0;
    else if (src_valid[0] && m_cnt < 255) m_cnt++;
    if (e_acc >= 0) begin
      m_pv = 1;
      m_pd = src_data[e_acc*DW +: DW];
    end else if (pipe_txready) begin
      m_pv = 0;
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    mode = 1'b0; weight = '0; starve_limit = '0; link_up = 1'b1;
    src_valid = '0; src_data = '0; src_last = '0; pipe_txready = 1'b1;
    @(negedge sclk);
    @(negedge sclk);
    srst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    srst = 1'b1;
    mode = 1'b0; weight = '0; starve_limit = '0; link_up = 1'b1; pipe_txready = 1'b1;
    src_valid = 3'b111; src_last = 3'b111; src_data = {NS{32'h5A5A_5A5A}};
    @(negedge sclk);
    #1;
    n_vec++; if (pipe_txvalid !== 1'b0) begin n_err++; $display("FAIL reset_txvalid: got %b want 0", pipe_txvalid); end
    n_vec++; if (pipe_txdata !== '0) begin n_err++; $display("FAIL reset_txdata: got %h want 0", pipe_txdata); end
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_vec++; if (src_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 000", src_ready); end
    n_vec++; if (starve_event !== 1'b0) begin n_err++; $display("FAIL reset_event: got %b want 0", starve_event); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    src_valid = 3'b011; src_last = 3'b011;
    src_data[0*DW +: DW] = 32'hD0D0_0000;
    src_data[1*DW +: DW] = 32'hD1D1_0001;
    #1;
    n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL fp_grant_first: got %b want 001", grant); end
    n_vec++; if (src_ready !== 3'b001) begin n_err++; $display("FAIL fp_ready_first: got %b want 001", src_ready); end
    @(negedge sclk);
    src_valid = 3'b010;
    #1;
    n_vec++; if (grant !== 3'b010) begin n_err++; $display("FAIL fp_grant_second: got %b want 010", grant); end
    n_vec++; if (pipe_txvalid !== 1'b1 || pipe_txdata !== 32'hD0D0_0000)
      begin n_err++; $display("FAIL fp_pipe_d0: got %b/%h want 1/d0d00000", pipe_txvalid, pipe_txdata); end
    @(negedge sclk);
    src_valid = 3'b000;
    #1;
    n_vec++; if (pipe_txvalid !== 1'b1 || pipe_txdata !== 32'hD1D1_0001)
      begin n_err++; $display("FAIL fp_pipe_d1: got %b/%h want 1/d1d10001", pipe_txvalid, pipe_txdata); end
    n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL fp_grant_idle: got %b want 000", grant); end
    @(negedge sclk);
    #1;
    n_vec++; if (pipe_txvalid !== 1'b0) begin n_err++; $display("FAIL fp_drain: got %b want 0", pipe_txvalid); end
  endtask

  task automatic test_wrr();
    logic [NS-1:0] want;
    do_reset();
    mode = 1'b1; weight = 12'h131;
    src_valid = 3'b111; src_last = 3'b111;
    for (int c = 0; c < 13; c++) begin
      #1;
      want = NS'(1) << wrr_exp[c];
      n_vec++; if (grant !== want) begin n_err++; $display("FAIL wrr_order[%0d]: got %b want %b", c, grant, want); end
      @(negedge sclk);
    end
  endtask

  task automatic test_burst_backpressure();
    do_reset();
    src_data[0*DW +: DW] = 32'hA000_0000;
    src_last[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      src_valid = bp_v[c];
      pipe_txready = bp_txr[c];
      src_data[1*DW +: DW] = 32'hB000_0000 | bp_beat[c];
      src_last[1] = (bp_beat[c] == 3);
      #1;
      n_vec++; if (src_ready !== bp_rdy[c]) begin n_err++; $display("FAIL burst_ready[%0d]: got %b want %b", c, src_ready, bp_rdy[c]); end
      n_vec++; if (grant !== bp_gnt[c]) begin n_err++; $display("FAIL burst_grant[%0d]: got %b want %b", c, grant, bp_gnt[c]); end
      n_vec++; if (pipe_txvalid !== bp_pv[c]) begin n_err++; $display("FAIL burst_txvalid[%0d]: got %b want %b", c, pipe_txvalid, bp_pv[c]); end
      if (bp_pv[c]) begin
        n_vec++; if (pipe_txdata !== bp_pd[c]) begin n_err++; $display("FAIL burst_txdata[%0d]: got %h want %h", c, pipe_txdata, bp_pd[c]); end
      end
      @(negedge sclk);
    end
  endtask

  task automatic test_starvation();
    logic [NS-1:0] want;
    do_reset();
    mode = 1'b1; weight = 12'h1F1; starve_limit = 8'd4;
    src_valid = 3'b011; src_last = 3'b011;
    for (int c = 0; c < 12; c++) begin
      #1;
      want = NS'(1) << stv_exp[c];
      n_vec++; if (grant !== want) begin n_err++; $display("FAIL starve_grant[%0d]: got %b want %b", c, grant, want); end
      n_vec++; if (starve_event !== (c == 7)) begin n_err++; $display("FAIL starve_event[%0d]: got %b want %b", c, starve_event, (c == 7)); end
      @(negedge sclk);
    end
  endtask

  task automatic test_link_gating();
    do_reset();
    link_up = 1'b0;
    src_valid = 3'b010; src_last = 3'b010;
    src_data[1*DW +: DW] = 32'hC0DE_0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (grant !== 3'b000 || src_ready !== 3'b000)
        begin n_err++; $display("FAIL link_down_hold[%0d]: got %b/%b want 000/000", c, grant, src_ready); end
      @(negedge sclk);
    end
    link_up = 1'b1;
    #1;
    n_vec++; if (grant !== 3'b010 || src_ready !== 3'b010)
      begin n_err++; $display("FAIL link_up_grant: got %b/%b want 010/010", grant, src_ready); end
    @(negedge sclk);
    src_valid = 3'b000;
    #1;
    n_vec++; if (pipe_txvalid !== 1'b1 || pipe_txdata !== 32'hC0DE_0001)
      begin n_err++; $display("FAIL link_up_beat: got %b/%h want 1/c0de0001", pipe_txvalid, pipe_txdata); end
    @(negedge sclk);
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 250 == 0) begin
        mode = 1'($urandom_range(0, 1));
        weight = 12'($urandom);
        starve_limit = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
      end
      link_up = ($urandom_range(0, 7) != 0);
      pipe_txready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++) begin
        if (s_left[i] == 0 && $urandom_range(0, 2) == 0) begin
          s_left[i] = $urandom_range(1, (i == 0) ? 2 : 4);
          s_data[i] = $urandom;
        end
        src_valid[i] = (s_left[i] > 0);
        src_last[i] = (s_left[i] == 1);
        src_data[i*DW +: DW] = s_data[i];
      end
      #1;
      model_eval();
      n_vec++; if (src_ready !== e_ready) begin n_err++; $display("FAIL rand_ready @%0d: got %b want %b", cyc, src_ready, e_ready); end
      n_vec++; if (grant !== e_grant) begin n_err++; $display("FAIL rand_grant @%0d: got %b want %b", cyc, grant, e_grant); end
      n_vec++; if (starve_event !== e_event) begin n_err++; $display("FAIL rand_event @%0d: got %b want %b", cyc, starve_event, e_event); end
      n_vec++; if (pipe_txvalid !== (m_pv != 0)) begin n_err++; $display("FAIL rand_txvalid @%0d: got %b want %0d", cyc, pipe_txvalid, m_pv); end
      if (m_pv != 0) begin
        n_vec++; if (pipe_txdata !== m_pd) begin n_err++; $display("FAIL rand_txdata @%0d: got %h want %h", cyc, pipe_txdata, m_pd); end
      end
      model_commit();
      for (int i = 0; i < NS; i++) begin
        if (e_acc == i) begin
          s_left[i]--;
          s_data[i] = $urandom;
        end
      end
      @(negedge sclk);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_wrr();
    test_burst_backpressure();
    test_starvation();
    test_link_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
